fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised forwarding and hazard unit for the integer pipeline; successor to the fixed 3-stage, 2-source forwarding unit.
- Resolves NSRC decode-stage source operands against NSTAGE in-flight pipeline stages, youngest first.
- Adds a register scoreboard for long-latency writers (divider, non-blocking loads) that have left the tracked stages.
- Adds a stall watchdog that flags a stall held longer than MAX_STALL cycles.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural registers; register x0 is hard-wired zero.
- RAW, 5, register address width (clog2 of NREG).
- NSRC, 2, decode source ports.
- NSTAGE, 3, forwarding stages; index 0 is the youngest (EX).
- MAX_STALL, 255, watchdog threshold in cycles (1..2^16-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs  in  NSRC*RAW  source register indices; port k at bits [k*RAW +: RAW].
- st_valid  in  NSTAGE  stage holds a valid instruction.
- st_wen  in  NSTAGE  stage instruction writes rd.
- st_ready  in  NSTAGE  stage result is available this cycle (for example, load in MEM with mem_ack).
- st_rd  in  NSTAGE*RAW  stage destination indices.
- st_dat  in  NSTAGE*XLEN  stage result data.
- lat_issue  in  1  long-latency op dispatched; sets its rd as pending.
- lat_issue_rd  in  RAW  destination of the issued op.
- lat_done  in  1  long-latency op wrote back; clears its rd.
- lat_done_rd  in  RAW  destination of the completed op.
- flush  in  1  pipeline flush.
- fwd  out  NSRC  per-source mux select (1 = use fwd_dat).
- fwd_dat  out  NSRC*XLEN  forwarded data.
- stall  out  1  hold decode.
- sb_pending  out  NREG  scoreboard state, registered.
- sb_err  out  1  sticky: issue to an already pending register.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  performance counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge) clears the following in one cycle:
  - sb_pending=0
  - sb_err=0
  - stall_timeout=0
  - stall counter=0
  - stall_cycles=0
- Combinational outputs during reset follow the rules below with sb_pending treated as 0.
- fwd, fwd_dat and stall are combinational with zero latency. fwd and fwd_dat are driven in all cases, so no latches are inferred.
- Per source k with rs=id_rs[k]:
  - If rs==0: fwd[k]=0, fwd_dat[k]=0, and source k never causes a stall.
  - Otherwise scan stages i=0..NSTAGE-1. The first i with st_valid[i] & st_wen[i] & st_rd[i]==rs is the match.
  - Match found and st_ready[i]=1: fwd[k]=1, fwd_dat[k]=st_dat[i].
  - Match found and st_ready[i]=0: fwd[k]=0, hazard.
  - No match and sb_pending[rs]=1: fwd[k]=0, hazard.
  - No match and not pending: fwd[k]=0, fwd_dat[k]=0.
  - Whenever fwd[k]=0, fwd_dat[k]=0.
  - Older matching stages are ignored once a younger match is found, even when the younger match is not ready.
- stall = id_valid & (any source has a hazard) & ~flush.
- Scoreboard update at each clock edge, evaluated in this order:
  - rst has the highest priority.
  - flush: next sb_pending=0 and the stall counter is cleared; lat_issue in the same cycle is then applied.
  - Otherwise: lat_done clears bit lat_done_rd, then lat_issue sets bit lat_issue_rd.
  - Set and clear of the same register in the same cycle results in pending=1.
  - Register index 0 is never set.
  - lat_issue to a register already pending (and not being cleared that cycle) sets sb_err=1.
  - lat_done to a register that is not pending has no effect and no error.
- Watchdog:
  - 16-bit counter increments on each cycle with stall=1 and clears on any cycle with stall=0 (or on flush).
  - The counter saturates at MAX_STALL.
  - On the edge where the counter reaches MAX_STALL, stall_timeout is set and stays set until rst.
  - stall is not modified by the watchdog.

Optional Feature:
- FWD_PERF_CNT_EN defined: stall_cycles is a 32-bit wrapping counter of cycles with stall=1.
  - It is cleared only by rst, not by flush.
  - It wraps from 0xFFFFFFFF to 0.
- FWD_PERF_CNT_EN not defined: stall_cycles is tied to 0 and the counter logic is not built.

Test Plan:
- rs={5,7}; stage0 rd=5 ready dat=0xAAAA_0001; stage1 rd=7 ready dat=0x1234 -> fwd=2'b11, dat0=0xAAAA_0001, dat1=0x1234, stall=0.
- rs0=5; stage0 rd=5 not ready; stage1 rd=5 ready -> stall=1, fwd[0]=0. Then raise st_ready[0] -> stall=0, data taken from stage0.
- lat_issue rd=9, then rs0=9 with no stage match -> stall=1 until lat_done rd=9. The cycle after done -> stall=0. Issue rd=9 twice with no done -> sb_err=1, sticky.
- Same cycle lat_done rd=4 and lat_issue rd=4 -> sb_pending[4]=1 next cycle. Issue rd=0 -> sb_pending[0]=0, and rs=0 never stalls.
- Hold a hazard with MAX_STALL=4 -> stall_timeout rises after the 4th stalled edge. Assert flush -> stall=0 and sb_pending=0, but stall_timeout stays 1 until rst.
- With FWD_PERF_CNT_EN, 10 stalled cycles, then rst mid-stall -> stall_cycles=10, then 0 one cycle after rst; all sticky flags are 0.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Forwarding, hazard detection and long-latency register scoreboard with stall watchdog.
// Optional stall performance counter is built when FWD_PERF_CNT_EN is defined.
module fwd_scoreboard #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int RAW       = 5,
    parameter int NSRC      = 2,
    parameter int NSTAGE    = 3,
    parameter int MAX_STALL = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NSRC*RAW-1:0]    id_rs,
    input  logic [NSTAGE-1:0]      st_valid,
    input  logic [NSTAGE-1:0]      st_wen,
    input  logic [NSTAGE-1:0]      st_ready,
    input  logic [NSTAGE*RAW-1:0]  st_rd,
    input  logic [NSTAGE*XLEN-1:0] st_dat,
    input  logic                   lat_issue,
    input  logic [RAW-1:0]         lat_issue_rd,
    input  logic                   lat_done,
    input  logic [RAW-1:0]         lat_done_rd,
    input  logic                   flush,
    output logic [NSRC-1:0]        fwd,
    output logic [NSRC*XLEN-1:0]   fwd_dat,
    output logic                   stall,
    output logic [NREG-1:0]        sb_pending,
    output logic                   sb_err,
    output logic                   stall_timeout,
    output logic [31:0]            stall_cycles
);

    localparam logic [15:0] MAX_CNT = 16'(MAX_STALL);

    logic [NREG-1:0] sb_pending_reg, sb_pending_next;
    logic [NREG-1:0] pend_eff;
    logic            sb_err_reg, sb_err_next;
    logic [15:0]     stall_cnt_reg, stall_cnt_next;
    logic            stall_timeout_reg, stall_timeout_next;
    logic [NSRC-1:0] hazard;

    // The scoreboard reads as empty while reset is asserted.
    assign pend_eff = rst ? '0 : sb_pending_reg;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            logic [RAW-1:0]  rs;
            logic            nz;
            logic            hit;
            logic            rdy;
            logic [XLEN-1:0] dat;

            assign rs = id_rs[gi*RAW +: RAW];
            assign nz = (rs != '0);

            // Scan oldest to youngest so the youngest matching stage wins.
            always_comb begin
                hit = 1'b0;
                rdy = 1'b0;
                dat = '0;
                for (int i = NSTAGE - 1; i >= 0; i--) begin
                    if (st_valid[i] && st_wen[i] && (st_rd[i*RAW +: RAW] == rs)) begin
                        hit = 1'b1;
                        rdy = st_ready[i];
                        dat = st_dat[i*XLEN +: XLEN];
                    end
                end
            end

            assign fwd[gi]                   = nz & hit & rdy;
            assign fwd_dat[gi*XLEN +: XLEN]  = fwd[gi] ? dat : '0;
            assign hazard[gi]                = nz & (hit ? ~rdy : pend_eff[rs]);
        end
    endgenerate

    assign stall = id_valid & (|hazard) & ~flush;

    always_comb begin
        sb_pending_next = flush ? '0 : sb_pending_reg;
        if (!flush && lat_done) begin
            sb_pending_next[lat_done_rd] = 1'b0;
        end
        sb_err_next = sb_err_reg;
        // Issue is applied after clear, so a same-cycle done/issue pair leaves the bit set.
        if (lat_issue && (lat_issue_rd != '0)) begin
            if (sb_pending_next[lat_issue_rd]) begin
                sb_err_next = 1'b1;
            end
            sb_pending_next[lat_issue_rd] = 1'b1;
        end

        stall_cnt_next = '0;
        if (stall) begin
            stall_cnt_next = (stall_cnt_reg >= MAX_CNT) ? stall_cnt_reg : stall_cnt_reg + 16'd1;
        end
        stall_timeout_next = stall_timeout_reg | (stall_cnt_next == MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_pending_reg    <= '0;
            sb_err_reg        <= 1'b0;
            stall_cnt_reg     <= '0;
            stall_timeout_reg <= 1'b0;
        end else begin
            sb_pending_reg    <= sb_pending_next;
            sb_err_reg        <= sb_err_next;
            stall_cnt_reg     <= stall_cnt_next;
            stall_timeout_reg <= stall_timeout_next;
        end
    end

    assign sb_pending    = sb_pending_reg;
    assign sb_err        = sb_err_reg;
    assign stall_timeout = stall_timeout_reg;

`ifdef FWD_PERF_CNT_EN
    logic [31:0] perf_cnt_reg;

    // Counts every stalled cycle since reset; flush does not clear it.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_reg <= '0;
        end else if (stall) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles = perf_cnt_reg;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized check of fwd_scoreboard against a rule-level reference model.
module tb_fwd_scoreboard;
    localparam int XLEN = 32, NREG = 32, RAW = 5, NSRC = 2, NSTAGE = 3, MAXS = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   id_valid;
    logic [NSRC*RAW-1:0]    id_rs;
    logic [NSTAGE-1:0]      st_valid, st_wen, st_ready;
    logic [NSTAGE*RAW-1:0]  st_rd;
    logic [NSTAGE*XLEN-1:0] st_dat;
    logic                   lat_issue, lat_done, flush;
    logic [RAW-1:0]         lat_issue_rd, lat_done_rd;
    logic [NSRC-1:0]        fwd;
    logic [NSRC*XLEN-1:0]   fwd_dat;
    logic                   stall;
    logic [NREG-1:0]        sb_pending;
    logic                   sb_err, stall_timeout;
    logic [31:0]            stall_cycles;

    fwd_scoreboard #(.XLEN(XLEN), .NREG(NREG), .RAW(RAW), .NSRC(NSRC),
                     .NSTAGE(NSTAGE), .MAX_STALL(MAXS)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs),
        .st_valid(st_valid), .st_wen(st_wen), .st_ready(st_ready),
        .st_rd(st_rd), .st_dat(st_dat),
        .lat_issue(lat_issue), .lat_issue_rd(lat_issue_rd),
        .lat_done(lat_done), .lat_done_rd(lat_done_rd), .flush(flush),
        .fwd(fwd), .fwd_dat(fwd_dat), .stall(stall), .sb_pending(sb_pending),
        .sb_err(sb_err), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Reference state
    bit [NREG-1:0] m_pend;
    bit            m_err, m_to;
    int            m_run;
    logic [31:0]   m_perf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_comb(output logic [NSRC-1:0] efwd,
                              output logic [NSRC*XLEN-1:0] edat, output logic estall);
        bit [NREG-1:0] pe;
        bit haz;
        pe  = rst ? '0 : m_pend;
        haz = 1'b0;
        efwd = '0;
        edat = '0;
        for (int k = 0; k < NSRC; k++) begin
            int found;
            logic [RAW-1:0] rs;
            rs = id_rs[k*RAW +: RAW];
            found = -1;
            if (rs != 0) begin
                for (int i = 0; i < NSTAGE; i++)
                    if (found < 0 && st_valid[i] && st_wen[i] && st_rd[i*RAW +: RAW] == rs)
                        found = i;
                if (found >= 0) begin
                    if (st_ready[found]) begin
                        efwd[k] = 1'b1;
                        edat[k*XLEN +: XLEN] = st_dat[found*XLEN +: XLEN];
                    end else haz = 1'b1;
                end else if (pe[rs]) haz = 1'b1;
            end
        end
        estall = id_valid & haz & ~flush;
    endtask

    task automatic model_seq();
        logic [NSRC-1:0] ef;
        logic [NSRC*XLEN-1:0] ed;
        logic es;
        model_comb(ef, ed, es);
        if (rst) begin
            m_pend = '0; m_err = 0; m_to = 0; m_run = 0; m_perf = 0;
        end else begin
            if (flush) m_pend = '0;
            else if (lat_done) m_pend[lat_done_rd] = 1'b0;
            if (lat_issue && lat_issue_rd != 0) begin
                if (m_pend[lat_issue_rd]) m_err = 1;
                m_pend[lat_issue_rd] = 1'b1;
            end
            m_run = es ? m_run + 1 : 0;
            if (m_run >= MAXS) m_to = 1;
            if (es) m_perf = m_perf + 32'd1;
        end
    endtask

    // One clock: check combinational outputs, advance model at the edge, check registers.
    task automatic cycle(input string tag);
        logic [NSRC-1:0] ef;
        logic [NSRC*XLEN-1:0] ed;
        logic es;
        logic [31:0] eperf;
        #1;
        model_comb(ef, ed, es);
        chk({tag, "_fwd"}, 64'(fwd), 64'(ef));
        chk({tag, "_fwd_dat"}, fwd_dat, ed);
        chk({tag, "_stall"}, 64'(stall), 64'(es));
        @(posedge clk);
        model_seq();
        #1;
`ifdef FWD_PERF_CNT_EN
        eperf = m_perf;
`else
        eperf = 32'd0;
`endif
        chk({tag, "_pending"}, 64'(sb_pending), 64'(m_pend));
        chk({tag, "_sb_err"}, 64'(sb_err), 64'(m_err));
        chk({tag, "_timeout"}, 64'(stall_timeout), 64'(m_to));
        chk({tag, "_stall_cycles"}, 64'(stall_cycles), 64'(eperf));
        $display("cycle %s: rs=%h fwd=%b stall=%b pend=%h err=%b to=%b cyc=%0d",
                 tag, id_rs, fwd, stall, sb_pending, sb_err, stall_timeout, stall_cycles);
        @(negedge clk);
    endtask

    task automatic clr_in();
        rst = 0; id_valid = 0; id_rs = '0; st_valid = '0; st_wen = '0; st_ready = '0;
        st_rd = '0; st_dat = '0; lat_issue = 0; lat_issue_rd = '0; lat_done = 0;
        lat_done_rd = '0; flush = 0;
    endtask

    task automatic set_st(input int i, input bit rdy, input logic [RAW-1:0] rd,
                          input logic [XLEN-1:0] d);
        st_valid[i] = 1'b1; st_wen[i] = 1'b1; st_ready[i] = rdy;
        st_rd[i*RAW +: RAW] = rd; st_dat[i*XLEN +: XLEN] = d;
    endtask

    initial begin
        m_pend = '0; m_err = 0; m_to = 0; m_run = 0; m_perf = 0;
        clr_in();
        rst = 1;
        @(negedge clk);
        cycle("reset");
        chk("reset_pending_zero", 64'(sb_pending), 64'd0);
        clr_in();

        // Two sources forwarded from different stages
        id_valid = 1; id_rs = {5'd7, 5'd5};
        set_st(0, 1, 5'd5, 32'hAAAA_0001);
        set_st(1, 1, 5'd7, 32'h0000_1234);
        #1;
        chk("tp1_fwd_const", 64'(fwd), 64'd3);
        chk("tp1_dat_const", fwd_dat, {32'h0000_1234, 32'hAAAA_0001});
        chk("tp1_stall_const", 64'(stall), 64'd0);
        cycle("tp1");

        // Younger not-ready match hides an older ready one
        clr_in();
        id_valid = 1; id_rs = {5'd0, 5'd5};
        set_st(0, 0, 5'd5, 32'h11);
        set_st(1, 1, 5'd5, 32'h22);
        #1;
        chk("tp2_stall_const", 64'(stall), 64'd1);
        chk("tp2_fwd0_const", 64'(fwd[0]), 64'd0);
        cycle("tp2a");
        st_ready[0] = 1'b1;
        #1;
        chk("tp2_stall_clear", 64'(stall), 64'd0);
        chk("tp2_dat_stage0", 64'(fwd_dat[31:0]), 64'h11);
        cycle("tp2b");

        // Scoreboard hazard until writeback, then double issue error
        clr_in();
        lat_issue = 1; lat_issue_rd = 5'd9;
        cycle("tp3_issue");
        clr_in();
        id_valid = 1; id_rs = {5'd0, 5'd9};
        #1;
        chk("tp3_stall_pending", 64'(stall), 64'd1);
        cycle("tp3_wait");
        lat_done = 1; lat_done_rd = 5'd9;
        cycle("tp3_done");
        lat_done = 0;
        #1;
        chk("tp3_stall_after_done", 64'(stall), 64'd0);
        cycle("tp3_free");
        lat_issue = 1; lat_issue_rd = 5'd9;
        cycle("tp3_iss1");
        cycle("tp3_iss2");
        chk("tp3_err_const", 64'(sb_err), 64'd1);
        clr_in();
        cycle("tp3_sticky");
        chk("tp3_err_sticky", 64'(sb_err), 64'd1);

        // Same-cycle done/issue, and x0 never pending
        lat_done = 1; lat_done_rd = 5'd4; lat_issue = 1; lat_issue_rd = 5'd4;
        cycle("tp4_setclr");
        chk("tp4_pend4", 64'(sb_pending[4]), 64'd1);
        clr_in();
        lat_issue = 1; lat_issue_rd = 5'd0; id_valid = 1; id_rs = '0;
        cycle("tp4_x0");
        chk("tp4_pend0", 64'(sb_pending[0]), 64'd0);

        // Watchdog and flush
        clr_in(); rst = 1;
        cycle("tp5_rst");
        clr_in();
        lat_issue = 1; lat_issue_rd = 5'd9;
        cycle("tp5_issue");
        clr_in();
        id_valid = 1; id_rs = {5'd0, 5'd9};
        for (int n = 0; n < 3; n++) cycle("tp5_hold");
        chk("tp5_to_before", 64'(stall_timeout), 64'd0);
        cycle("tp5_hold4");
        chk("tp5_to_after", 64'(stall_timeout), 64'd1);
        flush = 1;
        #1;
        chk("tp5_flush_stall", 64'(stall), 64'd0);
        cycle("tp5_flush");
        chk("tp5_flush_pend", 64'(sb_pending), 64'd0);
        chk("tp5_to_sticky", 64'(stall_timeout), 64'd1);

        // Perf counter across a reset in the middle of a stall
        clr_in(); rst = 1;
        cycle("tp6_rst");
        clr_in();
        lat_issue = 1; lat_issue_rd = 5'd3;
        cycle("tp6_issue");
        clr_in();
        id_valid = 1; id_rs = {5'd3, 5'd0};
        for (int n = 0; n < 10; n++) cycle("tp6_stall");
`ifdef FWD_PERF_CNT_EN
        chk("tp6_cycles10", 64'(stall_cycles), 64'd10);
`endif
        rst = 1;
        cycle("tp6_rst_mid");
        chk("tp6_cycles0", 64'(stall_cycles), 64'd0);
        chk("tp6_err0", 64'(sb_err), 64'd0);
        chk("tp6_to0", 64'(stall_timeout), 64'd0);
        rst = 0;

        // Randomized traffic on a small register window to provoke collisions
        for (int n = 0; n < 400; n++) begin
            clr_in();
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NSRC; k++) id_rs[k*RAW +: RAW] = RAW'($urandom_range(0, 7));
            for (int i = 0; i < NSTAGE; i++) begin
                st_valid[i] = $urandom_range(0, 1);
                st_wen[i]   = $urandom_range(0, 1);
                st_ready[i] = $urandom_range(0, 1);
                st_rd[i*RAW +: RAW]    = RAW'($urandom_range(0, 7));
                st_dat[i*XLEN +: XLEN] = $urandom;
            end
            lat_issue    = ($urandom_range(0, 3) == 0);
            lat_issue_rd = RAW'($urandom_range(0, 7));
            lat_done     = ($urandom_range(0, 2) == 0);
            lat_done_rd  = RAW'($urandom_range(0, 7));
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
